data_ram_ctrl: RTL and testbench
================================

# data_ram_ctrl

Parametrised, byte-addressed data memory for the core's load/store path. It generalises the fixed 32-bit data RAM in three ways: configurable data width and depth, a valid/ready request handshake with a response strobe, and correct handling of misaligned accesses that straddle a word boundary, which it performs as two sequenced word accesses. It sits between the load/store unit and on-chip storage. Reads return the accessed bytes zero- or sign-extended to full width.

## Interface
- DATA_W, 32, word width in bits; multiple of 8, at least 16; NB = DATA_W/8 byte lanes
- DEPTH, 256, number of words; byte address space is DEPTH*NB
- ADDR_W, 32, request address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  1  request present
- req_ready  out  1  block can accept; high only in IDLE
- req_we  in  1  1 = store, 0 = load
- req_type  in  NB  size mask; legal values are 2^S-1 for S = 1..NB (e.g. 0001 byte, 0011 half, 0111 three-quarter, 1111 word)
- req_addr  in  ADDR_W  byte address; any alignment
- req_wdat  in  DATA_W  store data; low S bytes used
- req_sign  in  1  load sign-extend enable
- rsp_valid  out  1  one-cycle completion strobe for loads and stores
- rsp_rdat  out  DATA_W  load result; 0 for stores and errors
- rsp_err  out  1  request rejected; qualified by rsp_valid

## Operation
- Little-endian. Word index W = A / NB. Byte offset O = A mod NB. Size S = popcount(req_type).
- An access is split when O+S > NB. The low part covers bytes O..NB-1 of word W. The high part covers bytes 0..O+S-NB-1 of word W+1.
- Error conditions:
  - req_type is not of the form 2^S-1.
  - A+S > DEPTH*NB. There is no wrap-around to word 0.
  - On error, no memory byte changes, and the response has rsp_err=1 and rsp_rdat=0.
- Store: byte k of req_wdat (k < S) is written to byte address A+k. No other bytes change.
- Load: byte k of the result is the byte at A+k. Bits above 8S-1 are filled with bit 8S-1 if req_sign=1, otherwise with 0.
- FSM states and transitions:
  - IDLE: on accept, go to RESP if the request is an error, otherwise go to ACC0.
  - ACC0: access word W; go to ACC1 if split, otherwise go to RESP.
  - ACC1: access word W+1; go to RESP.
  - RESP: assert rsp_valid; go to IDLE.
- The request (we, type, addr, wdat, sign) is latched at accept. Inputs are ignored outside IDLE.
- Storage is one single-port word array with per-byte write enables. Memory contents are not reset.
- Read-after-write: a load accepted after a store's rsp_valid observes the stored data.

## Timing
- Accept occurs on a rising edge with req_valid=1 and req_ready=1.
- For an accept on edge k, rsp_valid is high for exactly one cycle, ending at:
  - edge k+2 for an aligned or non-split access;
  - edge k+3 for a split access;
  - edge k+1 for an error.
- req_ready is low from the accept edge until the edge that leaves RESP. The earliest next accept is on the edge where RESP exits to IDLE plus one cycle.
- Back-to-back throughput: 1 request per 3 cycles non-split, 4 cycles split.
- rsp_rdat and rsp_err are registered. They are valid only while rsp_valid=1 and hold their last value otherwise.
- Reset values: state IDLE, req_ready=1 after deassertion, rsp_valid=0, rsp_rdat=0, rsp_err=0. req_ready=0 while rst_n=0.
- Reset mid-operation aborts immediately and no response is produced. For a split store, the word-W bytes are retained if reset hits after the ACC0 edge; word W+1 is not written.
- req_valid held high while req_ready=0 has no effect. The request must remain valid until accepted.

## Test plan (DATA_W=32, DEPTH=256)
- Aligned word: store 0x00000011 @0x04, then load word @0x04 -> rsp_valid 2 cycles after accept, rsp_rdat=0x00000011, rsp_err=0.
- Sign extension: store half 0x80AB @0x22.
  - Load half signed -> 0xFFFF80AB.
  - Load half unsigned -> 0x000080AB.
  - Store byte 0xC1 @0x0D, load byte signed -> 0xFFFFFFC1.
- Split access: store word 0xDEADBEEF @0x46 -> word 0x44 bytes 2..3 = EF,BE and word 0x48 bytes 0..1 = AD,DE; rsp_valid 3 cycles after accept. Load word @0x46 -> 0xDEADBEEF.
- Three-quarter store 0x00ABCDEF @0x45 with word 0x44 preloaded 0x11223344 -> word 0x44 = 0xABCDEF44; unsigned load -> 0x00ABCDEF, signed load -> 0xFFABCDEF.
- Errors, each giving rsp_err=1 one cycle after accept with memory unchanged:
  - req_type=0101;
  - req_type=0000;
  - word access @0x3FE (end of memory).
- Handshake and reset:
  - Hold req_valid high continuously -> accepts spaced exactly 3 (non-split) or 4 (split) cycles apart.
  - Assert rst_n=0 during ACC1 of a split store -> no rsp_valid, word W updated, word W+1 unchanged, req_ready=1 after release.

Source files
------------

// File: rtl/data_ram_ctrl_if.sv
// Request/response bus between the load/store unit and data_ram_ctrl.
// master : load/store unit drives the request and observes the response.
// slave  : data_ram_ctrl accepts requests and returns completion strobes.
// Signals: req_valid/req_ready handshake, req_we, req_type (byte-size mask),
//          req_addr (byte address), req_wdat, req_sign; rsp_valid, rsp_rdat, rsp_err.
interface data_ram_ctrl_if #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32
);
    localparam int unsigned NB = DATA_W / 8;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [NB-1:0]     req_type;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdat;
    logic              req_sign;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdat;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_type, req_addr, req_wdat, req_sign,
        input  req_ready, rsp_valid, rsp_rdat, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_type, req_addr, req_wdat, req_sign,
        output req_ready, rsp_valid, rsp_rdat, rsp_err
    );
endinterface

// File: rtl/data_ram_ctrl.sv
// Byte-addressed data memory for the load/store path. Accepts any-alignment
// loads and stores of 1..NB bytes; accesses crossing a word boundary are done
// as two sequential word accesses. Loads are zero- or sign-extended.
// Ports:
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - data_ram_ctrl_if.slave request/response bus
module data_ram_ctrl #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned DEPTH  = 256,
    parameter int unsigned ADDR_W = 32
) (
    input logic            clk,
    input logic            rst_n,
    data_ram_ctrl_if.slave bus
);
    localparam int unsigned NB = DATA_W / 8;
    localparam int unsigned OW = (NB > 1) ? $clog2(NB) : 1;
    localparam int unsigned SW = $clog2(NB + 1);
    localparam int unsigned CW = SW + 1;
    localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned EW = ADDR_W + 1;
    localparam longint unsigned MEM_BYTES = longint'(DEPTH) * longint'(NB);

    typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} state_t;

    state_t state_q, state_d;

    logic              we_q, sign_q, split_q;
    logic [NB-1:0]     type_q;
    logic [OW-1:0]     off_q;
    logic [IW-1:0]     widx_q;
    logic [DATA_W-1:0] wdat_q;
    logic [DATA_W-1:0] lo_q;

    logic              accept;
    logic [SW-1:0]     req_size;
    logic [OW-1:0]     req_off;
    logic              type_ok, range_ok, req_err, req_split;

    logic [2*NB-1:0]     be_ext;
    logic [2*DATA_W-1:0] wd_ext;
    logic [2*DATA_W-1:0] rd_join;
    logic [IW-1:0]       mem_idx;
    logic [NB-1:0]       mem_be;
    logic [DATA_W-1:0]   mem_wd, rd_word, ld_raw, ld_val;
    logic                ld_sgn;

    logic              rsp_valid_q, rsp_err_q, rsp_valid_d, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdat_q, rsp_rdat_d;

    logic [DATA_W-1:0] mem [DEPTH];

    // Ready is a state decode, forced low while reset is held.
    assign bus.req_ready = (state_q == IDLE) && rst_n;
    assign accept        = bus.req_valid && bus.req_ready;

    // Request decode: size, legality, bounds and word-crossing.
    always_comb begin
        req_size = '0;
        for (int b = 0; b < NB; b++) begin
            req_size = req_size + SW'(bus.req_type[b]);
        end
    end

    // A legal mask is a contiguous run of ones from bit 0 (2^S-1, S>=1).
    assign type_ok   = (bus.req_type != '0) &&
                       ((bus.req_type & (bus.req_type + NB'(1))) == '0);
    assign range_ok  = (EW'(bus.req_addr) + EW'(req_size)) <= EW'(MEM_BYTES);
    assign req_err   = !(type_ok && range_ok);
    assign req_off   = OW'(bus.req_addr % ADDR_W'(NB));
    assign req_split = (CW'(req_off) + CW'(req_size)) > CW'(NB);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = req_err ? RESP : ACC0;
            ACC0:    state_d = split_q ? ACC1 : RESP;
            ACC1:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request latch and low-word capture for split loads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            sign_q  <= 1'b0;
            split_q <= 1'b0;
            type_q  <= '0;
            off_q   <= '0;
            widx_q  <= '0;
            wdat_q  <= '0;
            lo_q    <= '0;
        end else begin
            if (accept) begin
                we_q    <= bus.req_we;
                sign_q  <= bus.req_sign;
                split_q <= req_split;
                type_q  <= bus.req_type;
                off_q   <= req_off;
                widx_q  <= IW'(bus.req_addr / ADDR_W'(NB));
                wdat_q  <= bus.req_wdat;
            end
            if (state_q == ACC0) begin
                lo_q <= rd_word;
            end
        end
    end

    // Output/datapath logic. Mask and data are shifted into a two-word
    // window: the low half targets word W, the high half word W+1.
    always_comb begin
        be_ext  = {{NB{1'b0}}, type_q} << off_q;
        wd_ext  = {{DATA_W{1'b0}}, wdat_q} << {off_q, 3'b000};
        mem_idx = (state_q == ACC1) ? IW'(widx_q + IW'(1)) : widx_q;
        mem_be  = '0;
        mem_wd  = wd_ext[DATA_W-1:0];
        if (we_q) begin
            if (state_q == ACC0) begin
                mem_be = be_ext[NB-1:0];
            end else if (state_q == ACC1) begin
                mem_be = be_ext[2*NB-1:NB];
                mem_wd = wd_ext[2*DATA_W-1:DATA_W];
            end
        end

        rd_word = mem[mem_idx];
        rd_join = (state_q == ACC1) ? {rd_word, lo_q} : {{DATA_W{1'b0}}, rd_word};
        ld_raw  = DATA_W'(rd_join >> {off_q, 3'b000});

        // Sign source is the top bit of the highest selected byte.
        ld_sgn = 1'b0;
        for (int b = 0; b < NB; b++) begin
            if (type_q[b]) ld_sgn = ld_raw[8*b+7];
        end
        ld_sgn = ld_sgn && sign_q;

        ld_val = '0;
        for (int b = 0; b < NB; b++) begin
            ld_val[8*b +: 8] = type_q[b] ? ld_raw[8*b +: 8] : {8{ld_sgn}};
        end

        rsp_valid_d = (state_d == RESP);
        rsp_err_d   = rsp_err_q;
        rsp_rdat_d  = rsp_rdat_q;
        if ((state_q == IDLE) && (state_d == RESP)) begin
            rsp_err_d  = 1'b1;
            rsp_rdat_d = '0;
        end else if (((state_q == ACC0) || (state_q == ACC1)) && (state_d == RESP)) begin
            rsp_err_d  = 1'b0;
            rsp_rdat_d = we_q ? '0 : ld_val;
        end
    end

    // Registered response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdat_q  <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdat_q  <= rsp_rdat_d;
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_rdat  = rsp_rdat_q;

    // Word storage with per-byte write enables; contents are not reset.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (mem_be[b]) mem[mem_idx][8*b +: 8] <= mem_wd[8*b +: 8];
        end
    end
endmodule

// File: tb/tb_data_ram_ctrl.sv
// Self-checking bench for data_ram_ctrl (DATA_W=32, DEPTH=256).
// Requests are issued through a driver task; expected responses are queued at
// accept time and checked by a monitor when rsp_valid appears.
module tb_data_ram_ctrl;
    localparam int unsigned DATA_W    = 32;
    localparam int unsigned DEPTH     = 256;
    localparam int unsigned ADDR_W    = 32;
    localparam int unsigned MEM_BYTES = 1024;

    typedef struct {
        logic        we;
        logic [3:0]  typ;
        logic [31:0] addr;
        logic [31:0] wdat;
        logic        sign;
        logic [31:0] exp_rdat;
        logic        exp_err;
        int          exp_lat;   // 0 = take expectation from the byte model
    } vec_t;

    typedef struct {
        logic [31:0] rdat;
        logic        err;
        int          end_edge;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    data_ram_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

    data_ram_ctrl #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    exp_t sb[$];
    logic prev_v = 1'b0;
    bit   check_gap = 1'b0;
    bit   gap_first = 1'b1;
    int   last_acc = 0;
    int   last_lat = 0;
    byte unsigned mem_m [MEM_BYTES];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference byte-level model; updates mem_m for successful stores.
    function automatic void model(input vec_t v, output logic [31:0] rdat,
                                  output logic err, output int lat);
        int sz, off;
        logic [9:0] ai;
        logic [31:0] r;
        sz = 0;
        case (v.typ)
            4'h1: sz = 1;
            4'h3: sz = 2;
            4'h7: sz = 3;
            4'hF: sz = 4;
            default: sz = 0;
        endcase
        err  = (sz == 0) || ((longint'(v.addr) + longint'(sz)) > longint'(MEM_BYTES));
        rdat = '0;
        lat  = 1;
        if (!err) begin
            off = int'(v.addr % 32'd4);
            lat = (off + sz > 4) ? 3 : 2;
            r = '0;
            for (int k = 0; k < sz; k++) begin
                ai = 10'(v.addr + 32'(k));
                if (v.we) mem_m[ai] = v.wdat[8*k +: 8];
                else      r[8*k +: 8] = mem_m[ai];
            end
            if (!v.we && v.sign && r[8*sz-1]) begin
                for (int k = sz; k < 4; k++) r[8*k +: 8] = 8'hFF;
            end
            rdat = v.we ? 32'h0 : r;
        end
    endfunction

    function automatic vec_t mk(input logic we, input logic [3:0] typ, input logic [31:0] addr,
                                input logic [31:0] wdat, input logic sign,
                                input logic [31:0] rdat, input logic err, input int lat);
        vec_t v;
        v.we = we; v.typ = typ; v.addr = addr; v.wdat = wdat; v.sign = sign;
        v.exp_rdat = rdat; v.exp_err = err; v.exp_lat = lat;
        return v;
    endfunction

    // Drive one request starting at a falling edge; returns one falling edge after accept.
    task automatic issue(input vec_t v, input bit track, input string name);
        int t;
        logic [31:0] mr;
        logic me;
        int ml;
        exp_t e;
        bus.req_valid = 1'b1;
        bus.req_we    = v.we;
        bus.req_type  = v.typ;
        bus.req_addr  = v.addr;
        bus.req_wdat  = v.wdat;
        bus.req_sign  = v.sign;
        t = 0;
        while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!bus.req_ready) begin
            n_chk++;
            n_fail++;
            $display("FAIL %s accept_timeout: req_ready stayed 0", name);
            bus.req_valid = 1'b0;
            return;
        end
        model(v, mr, me, ml);
        if (track) begin
            if (check_gap) begin
                if (!gap_first) chk({name, "_accept_gap"}, 32'(cyc + 1 - last_acc), 32'(last_lat + 1));
                gap_first = 1'b0;
            end
            e.name = name;
            if (v.exp_lat != 0) begin
                e.rdat = v.exp_rdat; e.err = v.exp_err; e.end_edge = cyc + 1 + v.exp_lat;
                last_lat = v.exp_lat;
            end else begin
                e.rdat = mr; e.err = me; e.end_edge = cyc + 1 + ml;
                last_lat = ml;
            end
            last_acc = cyc + 1;
            sb.push_back(e);
        end
        @(negedge clk);
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (sb.size() != 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain_timeout: %0d responses outstanding", sb.size());
            sb.delete();
        end
    endtask

    // Response monitor: one-cycle strobe, data, error flag and completion edge.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && bus.rsp_valid) begin
            n_chk++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_rsp: rdat=0x%08h err=%0b with nothing outstanding",
                         bus.rsp_rdat, bus.rsp_err);
            end else begin
                e = sb.pop_front();
                if (bus.rsp_rdat !== e.rdat || bus.rsp_err !== e.err ||
                    (cyc + 1) != e.end_edge || prev_v) begin
                    n_fail++;
                    $display("FAIL %s: got rdat=0x%08h err=%0b end_edge=%0d held=%0b expected rdat=0x%08h err=%0b end_edge=%0d held=0",
                             e.name, bus.rsp_rdat, bus.rsp_err, cyc + 1, prev_v, e.rdat, e.err, e.end_edge);
                end
            end
        end
        prev_v = rst_n && bus.rsp_valid;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tab[$];
        vec_t v;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_type  = '0;
        bus.req_addr  = '0;
        bus.req_wdat  = '0;
        bus.req_sign  = 1'b0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("reset_ready_low", 32'(bus.req_ready), 32'd0);
        chk("reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("reset_rsp_rdat", bus.rsp_rdat, 32'd0);
        chk("reset_rsp_err", 32'(bus.rsp_err), 32'd0);
        rst_n = 1'b1;
        #1 chk("ready_after_reset", 32'(bus.req_ready), 32'd1);
        @(negedge clk);

        // Clear all of memory so the model starts fully known
        for (int w = 0; w < int'(DEPTH); w++) begin
            issue(mk(1'b1, 4'hF, 32'(4 * w), 32'h0, 1'b0, 32'h0, 1'b0, 0), 1'b1, "init");
        end
        drain();

        // Directed table
        tab.push_back(mk(1, 4'hF, 32'h04, 32'h00000011, 0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'hF, 32'h04, 32'h0,        0, 32'h00000011, 0, 2));
        tab.push_back(mk(1, 4'h3, 32'h22, 32'h000080AB, 0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'h3, 32'h22, 32'h0,        1, 32'hFFFF80AB, 0, 2));
        tab.push_back(mk(0, 4'h3, 32'h22, 32'h0,        0, 32'h000080AB, 0, 2));
        tab.push_back(mk(1, 4'h1, 32'h0D, 32'h000000C1, 0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'h1, 32'h0D, 32'h0,        1, 32'hFFFFFFC1, 0, 2));
        tab.push_back(mk(1, 4'hF, 32'h46, 32'hDEADBEEF, 0, 32'h0,        0, 3));
        tab.push_back(mk(0, 4'hF, 32'h44, 32'h0,        0, 32'hBEEF0000, 0, 2));
        tab.push_back(mk(0, 4'hF, 32'h48, 32'h0,        0, 32'h0000DEAD, 0, 2));
        tab.push_back(mk(0, 4'hF, 32'h46, 32'h0,        0, 32'hDEADBEEF, 0, 3));
        tab.push_back(mk(1, 4'hF, 32'h44, 32'h11223344, 0, 32'h0,        0, 2));
        tab.push_back(mk(1, 4'h7, 32'h45, 32'h00ABCDEF, 0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'hF, 32'h44, 32'h0,        0, 32'hABCDEF44, 0, 2));
        tab.push_back(mk(0, 4'h7, 32'h45, 32'h0,        0, 32'h00ABCDEF, 0, 2));
        tab.push_back(mk(0, 4'h7, 32'h45, 32'h0,        1, 32'hFFABCDEF, 0, 2));
        tab.push_back(mk(0, 4'h5, 32'h00, 32'h0,        0, 32'h0,        1, 1));
        tab.push_back(mk(1, 4'h5, 32'h10, 32'hFFFFFFFF, 0, 32'h0,        1, 1));
        tab.push_back(mk(1, 4'h0, 32'h10, 32'hFFFFFFFF, 0, 32'h0,        1, 1));
        tab.push_back(mk(1, 4'hF, 32'h3FE, 32'hFFFFFFFF, 0, 32'h0,       1, 1));
        tab.push_back(mk(0, 4'hF, 32'h10, 32'h0,        0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'h3, 32'h3FE, 32'h0,       0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'hF, 32'h3FC, 32'h0,       0, 32'h0,        0, 2));
        tab.push_back(mk(0, 4'h1, 32'h400, 32'h0,       0, 32'h0,        1, 1));
        tab.push_back(mk(0, 4'hF, 32'hFFFFFFFE, 32'h0,  0, 32'h0,        1, 1));
        foreach (tab[i]) begin
            issue(tab[i], 1'b1, $sformatf("vec%0d", i));
        end
        drain();

        // Valid held high: accepts spaced by latency + 1
        check_gap = 1'b1;
        gap_first = 1'b1;
        issue(mk(0, 4'hF, 32'h04, 32'h0, 0, 32'h0, 0, 0), 1'b1, "hold_a");
        issue(mk(0, 4'hF, 32'h46, 32'h0, 0, 32'h0, 0, 0), 1'b1, "hold_b");
        issue(mk(0, 4'hF, 32'h45, 32'h0, 1, 32'h0, 0, 0), 1'b1, "hold_c");
        issue(mk(0, 4'h3, 32'h22, 32'h0, 1, 32'h0, 0, 0), 1'b1, "hold_d");
        issue(mk(1, 4'h3, 32'h47, 32'h00005A5A, 0, 32'h0, 0, 0), 1'b1, "hold_e");
        issue(mk(0, 4'h3, 32'h47, 32'h0, 0, 32'h0, 0, 0), 1'b1, "hold_f");
        check_gap = 1'b0;
        drain();

        // Random mix against the byte model
        for (int i = 0; i < 200; i++) begin
            v.we   = 1'($urandom_range(0, 1));
            v.sign = 1'($urandom_range(0, 1));
            v.wdat = $urandom;
            v.addr = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1016, 1027))
                                                 : 32'($urandom_range(0, 1023));
            if ($urandom_range(0, 7) == 0) v.typ = 4'($urandom_range(0, 15));
            else begin
                case ($urandom_range(0, 3))
                    0:       v.typ = 4'h1;
                    1:       v.typ = 4'h3;
                    2:       v.typ = 4'h7;
                    default: v.typ = 4'hF;
                endcase
            end
            v.exp_rdat = '0; v.exp_err = 1'b0; v.exp_lat = 0;
            issue(v, 1'b1, $sformatf("rand%0d", i));
        end
        drain();

        // Reset during ACC1 of a split store
        issue(mk(1, 4'hF, 32'h84, 32'h0, 0, 32'h0, 0, 2), 1'b1, "pre_rst_a");
        issue(mk(1, 4'hF, 32'h88, 32'h0, 0, 32'h0, 0, 2), 1'b1, "pre_rst_b");
        drain();
        issue(mk(1, 4'hF, 32'h86, 32'hCAFEF00D, 0, 32'h0, 0, 3), 1'b0, "split_rst");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ready", 32'(bus.req_ready), 32'd0);
        chk("rst_mid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        chk("rst_hold_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rst_release_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_release_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        @(negedge clk);
        mem_m[10'h86] = 8'h0D;
        mem_m[10'h87] = 8'hF0;
        issue(mk(0, 4'hF, 32'h84, 32'h0, 0, 32'hF00D0000, 0, 2), 1'b1, "post_rst_w");
        issue(mk(0, 4'hF, 32'h88, 32'h0, 0, 32'h00000000, 0, 2), 1'b1, "post_rst_w1");
        drain();
        repeat (3) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
